// File: rtl/secuencia_generador.sv
// Serial bit-sequence transmitter: shifts a latched WIDTH-bit pattern out MSB-first,
// repeated reps times with GAP_LEN idle cycles between repetitions, then pulses done.
module secuencia_generador #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    output logic             w,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   pat_q;
    logic [WIDTH-1:0]   shift_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   rep_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               w_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;

    // bit_cnt_q holds the number of pattern bits still to follow the one on w
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            w_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    w_q     <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (start) begin
                        if (reps != '0) begin
                            pat_q     <= pattern;
                            shift_q   <= pattern;
                            rep_cnt_q <= reps;
                            bit_cnt_q <= BIT_LAST;
                            w_q       <= pattern[WIDTH-1];
                            valid_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_SEND;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (bit_cnt_q != '0) begin
                        shift_q   <= shift_q << 1;
                        w_q       <= shift_q[WIDTH-2];
                        bit_cnt_q <= bit_cnt_q - BIT_W'(1);
                    end else if (rep_cnt_q == CNT_W'(1)) begin
                        rep_cnt_q <= '0;
                        w_q       <= 1'b0;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (GAP_LEN > 0) begin
                        rep_cnt_q <= rep_cnt_q - CNT_W'(1);
                        gap_cnt_q <= GAP_LAST;
                        w_q       <= 1'b0;
                        valid_q   <= 1'b0;
                        state_q   <= S_GAP;
                    end else begin
                        // back-to-back repetition: reload without a gap
                        rep_cnt_q <= rep_cnt_q - CNT_W'(1);
                        shift_q   <= pat_q;
                        bit_cnt_q <= BIT_LAST;
                        w_q       <= pat_q[WIDTH-1];
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end else begin
                        shift_q   <= pat_q;
                        bit_cnt_q <= BIT_LAST;
                        w_q       <= pat_q[WIDTH-1];
                        valid_q   <= 1'b1;
                        state_q   <= S_SEND;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign w     = w_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
